// File: rtl/sia_rxq_pkg.sv
// Shared types and widths for the SIA receive queue.
package sia_rxq_pkg;

  localparam int unsigned BIT_CNT_W = 6;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } rx_state_e;

endpackage

// File: rtl/sia_rxq_fifo.sv
// Small push/pop FIFO of raw frames with a combinational, gated head output.
module sia_rxq_fifo #(
  parameter int unsigned DEPTH_BITS = 2,
  parameter int unsigned DATA_BITS  = 12
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 push,
  input  logic [DATA_BITS-1:0] push_dat,
  input  logic                 pop,
  input  logic                 oe,
  output logic [DATA_BITS-1:0] dat_c,
  output logic                 full_c,
  output logic                 not_empty_c
);

  localparam int unsigned DEPTH = 1 << DEPTH_BITS;

  logic [DATA_BITS-1:0]  mem [DEPTH];
  logic [DEPTH_BITS-1:0] rd_ptr;
  logic [DEPTH_BITS-1:0] wr_ptr;
  logic [DEPTH_BITS:0]   count;
  logic                  push_ok;
  logic                  pop_ok;

  always_comb begin
    full_c      = (count == (DEPTH_BITS + 1)'(DEPTH));
    not_empty_c = (count != '0);
    push_ok     = push && !full_c;
    pop_ok      = pop && not_empty_c;
    dat_c       = oe ? mem[rd_ptr] : '0;
  end

  // Storage carries no reset; the head shows stale data when empty.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + DEPTH_BITS'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + DEPTH_BITS'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (DEPTH_BITS + 1)'(1);
        2'b01:   count <= count - (DEPTH_BITS + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sia_rxq.sv
// SIA receiver: resynchronised baud sampler, shift register and frame FSM
// pushing raw frames into a CPU-readable FIFO.
module sia_rxq
  import sia_rxq_pkg::*;
#(
  parameter int unsigned SHIFT_REG_WIDTH = 12,
  parameter int unsigned BAUD_RATE_WIDTH = 32,
  parameter int unsigned DEPTH_BITS      = 2,
  parameter int unsigned DATA_BITS       = 12
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [BIT_CNT_W-1:0]       bits_i,
  input  logic [BAUD_RATE_WIDTH-1:0] baud_i,
  input  logic                       eedd_i,
  input  logic                       eedc_i,
  input  logic                       rxd_i,
  input  logic                       rxc_i,
  input  logic                       rxq_pop_i,
  input  logic                       rxq_oe_i,
  output logic [DATA_BITS-1:0]       rxq_dat_o,
  output logic                       rxq_full_o,
  output logic                       rxq_not_empty_o
);

  logic                       rxd_meta, rxd_sync, rxd_last;
  logic                       rxc_meta, rxc_sync, rxc_last;
  logic [BAUD_RATE_WIDTH-1:0] baud_cnt;
  logic [SHIFT_REG_WIDTH-1:0] shreg;
  logic [SHIFT_REG_WIDTH-1:0] shift_nxt_c;
  logic                       edge_c;
  logic                       strobe_c;
  logic                       push_c;
  rx_state_e                  state, state_nxt;
  logic [BIT_CNT_W-1:0]       bit_cnt, bit_cnt_nxt, bit_cnt_inc_c;

  // Two-flop synchronisers plus one history flop for edge detection.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_last <= 1'b1;
      rxc_meta <= 1'b0;
      rxc_sync <= 1'b0;
      rxc_last <= 1'b0;
    end else begin
      rxd_meta <= rxd_i;
      rxd_sync <= rxd_meta;
      rxd_last <= rxd_sync;
      rxc_meta <= rxc_i;
      rxc_sync <= rxc_meta;
      rxc_last <= rxc_sync;
    end
  end

  always_comb begin
    edge_c        = (eedd_i && (rxd_sync != rxd_last)) ||
                    (eedc_i && (rxc_sync != rxc_last));
    strobe_c      = (baud_cnt == '0);
    shift_nxt_c   = {rxd_sync, shreg[SHIFT_REG_WIDTH-1:1]};
    bit_cnt_inc_c = bit_cnt + BIT_CNT_W'(1);
  end

  // Edge resync lands the next strobe mid-bit and wins over the zero reload.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      baud_cnt <= baud_i;
    end else if (edge_c) begin
      baud_cnt <= baud_i >> 1;
    end else if (strobe_c) begin
      baud_cnt <= baud_i;
    end else begin
      baud_cnt <= baud_cnt - BAUD_RATE_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      shreg <= '1;
    end else if (strobe_c) begin
      shreg <= shift_nxt_c;
    end
  end

  // Frame FSM: state register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
    end
  end

  // Frame FSM: next state
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    case (state)
      ST_IDLE: begin
        if (strobe_c && !rxd_sync) begin
          state_nxt   = ST_RECV;
          bit_cnt_nxt = BIT_CNT_W'(1);
        end
      end
      ST_RECV: begin
        if (strobe_c) begin
          bit_cnt_nxt = bit_cnt_inc_c;
          if (bit_cnt_inc_c == bits_i) begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Frame FSM: outputs
  always_comb begin
    push_c = 1'b0;
    if (state == ST_RECV && strobe_c && bit_cnt_inc_c == bits_i) begin
      push_c = 1'b1;
    end
  end

  sia_rxq_fifo #(
    .DEPTH_BITS (DEPTH_BITS),
    .DATA_BITS  (DATA_BITS)
  ) u_fifo (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .push        (push_c),
    .push_dat    (DATA_BITS'(shift_nxt_c)),
    .pop         (rxq_pop_i),
    .oe          (rxq_oe_i),
    .dat_c       (rxq_dat_o),
    .full_c      (rxq_full_o),
    .not_empty_c (rxq_not_empty_o)
  );

endmodule

// File: tb/tb_sia_rxq.sv
// Directed bench for sia_rxq: serial frames at 50 clocks/bit, table-driven FIFO pops.
module tb_sia_rxq;

  localparam int unsigned BIT_CLKS = 50;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [5:0]  bits_i;
  logic [31:0] baud_i;
  logic        eedd_i, eedc_i, rxd_i, rxc_i;
  logic        rxq_pop_i, rxq_oe_i;
  logic [11:0] rxq_dat_o;
  logic        rxq_full_o, rxq_not_empty_o;

  typedef struct {
    logic        pop;
    logic        oe;
    logic [11:0] dat;
    logic        full;
    logic        ne;
  } vec_t;

  vec_t vecs[11];
  int   tests = 0;
  int   fails = 0;

  sia_rxq dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .bits_i          (bits_i),
    .baud_i          (baud_i),
    .eedd_i          (eedd_i),
    .eedc_i          (eedc_i),
    .rxd_i           (rxd_i),
    .rxc_i           (rxc_i),
    .rxq_pop_i       (rxq_pop_i),
    .rxq_oe_i        (rxq_oe_i),
    .rxq_dat_o       (rxq_dat_o),
    .rxq_full_o      (rxq_full_o),
    .rxq_not_empty_o (rxq_not_empty_o)
  );

  always #10 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // 8N1 frame preceded by two idle/one bits, as it sits in the shift register.
  function automatic logic [11:0] frame_word(input logic [7:0] b);
    return {1'b1, b, 1'b0, 2'b11};
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      rxq_pop_i = vecs[i].pop;
      rxq_oe_i  = vecs[i].oe;
      @(posedge clk_i); #1;
      check($sformatf("vec%0d dat", i), rxq_dat_o, vecs[i].dat);
      check($sformatf("vec%0d full", i), {11'b0, rxq_full_o}, {11'b0, vecs[i].full});
      check($sformatf("vec%0d not_empty", i), {11'b0, rxq_not_empty_o}, {11'b0, vecs[i].ne});
    end
    rxq_pop_i = 1'b0;
  endtask

  task automatic idle(input int n);
    rxd_i = 1'b1;
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic send_bits(input logic [9:0] f, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      rxd_i = f[i];
      repeat (BIT_CLKS) @(posedge clk_i);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits({1'b1, b, 1'b0}, 10);
  endtask

  task automatic check_flags(input string name, input logic full, input logic ne);
    check({name, " full"}, {11'b0, rxq_full_o}, {11'b0, full});
    check({name, " not_empty"}, {11'b0, rxq_not_empty_o}, {11'b0, ne});
  endtask

  initial begin
    // Empty pops with oe low, then head/pop sequence on a full FIFO.
    for (int i = 0; i < 4; i++) vecs[i] = '{1'b1, 1'b0, 12'h000, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, frame_word(8'h85), 1'b1, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, frame_word(8'h85), 1'b1, 1'b1};
    vecs[6]  = '{1'b1, 1'b1, frame_word(8'hA1), 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, frame_word(8'h85), 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, frame_word(8'hA1), 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, frame_word(8'h85), 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b1, frame_word(8'h85), 1'b0, 1'b0};

    reset_i   = 1'b1;
    bits_i    = 6'd10;
    baud_i    = 32'd49;
    eedd_i    = 1'b1;
    eedc_i    = 1'b1;
    rxd_i     = 1'b1;
    rxc_i     = 1'b0;
    rxq_pop_i = 1'b0;
    rxq_oe_i  = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check_flags("in reset", 1'b0, 1'b0);
    reset_i = 1'b0;
    idle(2);

    run_vec(0, 3);
    idle(100);

    send_byte(8'h85);
    check_flags("after 1st frame", 1'b0, 1'b1);
    send_byte(8'hA1);
    send_byte(8'h85);
    send_byte(8'hA1);
    check_flags("after 4th frame", 1'b1, 1'b1);

    // Fifth frame arrives while full and must be dropped.
    send_byte(8'h3C);
    check_flags("after dropped frame", 1'b1, 1'b1);

    run_vec(4, 10);

    idle(100);
    send_byte(8'h3C);
    rxq_oe_i = 1'b1;
    #1;
    check("refill head", rxq_dat_o, frame_word(8'h3C));
    check_flags("refill", 1'b0, 1'b1);

    // Reset in the middle of a frame: start bit plus three data bits of 0x5A.
    send_bits({1'b1, 8'h5A, 1'b0}, 4);
    repeat (20) @(posedge clk_i);
    #1;
    reset_i = 1'b1;
    rxd_i   = 1'b1;
    repeat (5) @(posedge clk_i);
    #1;
    check_flags("mid-frame reset", 1'b0, 1'b0);
    reset_i = 1'b0;
    idle(120);
    check_flags("idle after reset", 1'b0, 1'b0);

    send_byte(8'h96);
    check("post-reset head", rxq_dat_o, frame_word(8'h96));
    check_flags("post-reset frame", 1'b0, 1'b1);
    rxq_pop_i = 1'b1;
    @(posedge clk_i); #1;
    rxq_pop_i = 1'b0;
    check_flags("post-reset pop", 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sia_rxq.md
Name: sia_rxq

Overview:
- Receive half of the serial interface adapter (SIA): an asynchronous serial receiver (baud generator, edge resync, shift register) feeding a small FIFO of raw received frames.
- The CPU-side bus pops frames and reads the FIFO head.
- Frames are stored unformatted: start, data and stop bits as they appear in the shift register. Software extracts the fields.

Parameters:
- SHIFT_REG_WIDTH, 12, width of the receive shift register in bits.
- BAUD_RATE_WIDTH, 32, width of baud_i and of the baud down-counter.
- DEPTH_BITS, 2, log2 of FIFO depth (default depth 4).
- DATA_BITS, 12, width of each FIFO entry and of rxq_dat_o. It must equal SHIFT_REG_WIDTH.

Ports:
- clk_i, in, 1: system clock.
- reset_i, in, 1: asynchronous, active-high reset.
- bits_i, in, 6: frame length in bit times, including start and stop bits (10 = 8N1).
- baud_i, in, BAUD_RATE_WIDTH: bit period minus 1, in clk_i cycles (49 gives 1 Mbps at 50 MHz).
- eedd_i, in, 1: enable resync of the baud counter on rxd edges.
- eedc_i, in, 1: enable resync of the baud counter on rxc edges.
- rxd_i, in, 1: serial data line; idles high.
- rxc_i, in, 1: optional external serial clock.
- rxq_pop_i, in, 1: advance the FIFO read pointer.
- rxq_oe_i, in, 1: output enable for rxq_dat_o.
- rxq_dat_o, out, DATA_BITS: FIFO head entry when enabled, else 0.
- rxq_full_o, out, 1: FIFO holds 2^DEPTH_BITS entries.
- rxq_not_empty_o, out, 1: FIFO holds at least one entry.

Behaviour:
- Input synchronisation: rxd_i and rxc_i each pass through a 2-flop synchroniser. The rxd synchroniser resets to 1, the rxc synchroniser to 0. An edge is any change between the last two synchronised samples.
- Baud counter:
  - Counts down from baud_i.
  - At 0 it emits a one-cycle sample strobe and reloads baud_i, giving a period of baud_i+1 clocks.
  - A detected rxd edge with eedd_i=1, or rxc edge with eedc_i=1, reloads the counter with baud_i>>1, so the next strobe falls mid-bit.
  - An edge takes precedence over the zero-reload in the same cycle.
- Shift register:
  - Resets to all ones.
  - On every strobe it shifts right by one; the synchronised rxd enters the MSB.
  - The oldest bit lands at bit[SHIFT_REG_WIDTH-bits_i]. For 8N1 in 12 bits this gives {stop, d7..d0, start, 2 older bits}.
- Frame FSM:
  - States: IDLE and RECV, plus a bit counter of width 6.
  - IDLE: on a strobe with rxd=0 (start bit), go to RECV with count=1.
  - RECV: each strobe increments count. When the incremented count equals bits_i, push the post-shift register value into the FIFO and return to IDLE.
  - No stop-bit validation.
- FIFO:
  - Depth 2^DEPTH_BITS. Read and write pointers are DEPTH_BITS wide and wrap naturally; an occupancy counter of DEPTH_BITS+1 bits is kept.
  - A push is accepted only when not full. A frame arriving while full is dropped.
  - A pop is honoured only when not empty. Pop on empty is ignored; the pointer does not move.
  - Simultaneous push and pop are both honoured, subject to the full/empty state at that cycle; the count is unchanged.
  - rxq_full_o and rxq_not_empty_o are combinational from the count.
  - rxq_dat_o = rxq_oe_i ? mem[rd_ptr] : 0, combinational with no read latency. After a pop, the next head is visible in the following cycle.
  - When empty, rxq_dat_o still shows mem[rd_ptr], i.e. stale data.
  - Storage is not reset.
- Reset, including mid-frame:
  - Pointers and count go to 0; outputs not_empty=0 and full=0.
  - FSM goes to IDLE, shift register to all ones, baud counter to baud_i.

Decomposition:
- No shared package needed. Frame-format constants (e.g. the 8N1 frame length of 10) may live in a shared sia_pkg if other SIA blocks need them.
- One natural sub-module: sia_rxq_fifo (parameterised push/pop FIFO with full/not_empty and gated output).

Test Plan:
- Reset, pop x4 on empty with oe=0 -> rxq_dat_o=000, not_empty=0, full=0, pointers unmoved.
- Configuration for the remaining scenarios: bits=10, baud=49 at 50 MHz, eedd=eedc=1. Send 8N1 frame 0x85 LSB first (1 us/bit) -> after 10 us not_empty=1, full=0.
- Send 0xA1, 0x85, 0xA1 back-to-back -> full=1 after the 4th frame. With oe=1, head=12'b1_10000101_0_11, stable over 2 cycles without pop.
- Hold pop -> successive cycles show 12'b1_10100001_0_11 (full=0), then 0x85's frame, then 0xA1's frame. After the last pop, not_empty=0 and dat wraps to 12'b1_10000101_0_11; it stays there with pop held.
- Send a 5th frame while full -> dropped; FIFO contents and order unchanged.
- Assert reset mid-frame -> FIFO empty, receiver IDLE; a following clean frame is received correctly.
